// File: rtl/output_capture_fifo.sv
// Capture FIFO for the (a|b)^constant stage output.
// Buffers words and keeps a running XOR signature, word count and stall flag.
module output_capture_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sig,
   output logic [15:0]      word_cnt,
   output logic             stall_seen
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push;
   logic             pop;

   // Handshake status comes only from registered occupancy.
   assign in_ready  = (count < FULL);
   assign out_valid = (count != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

   assign push = in_valid & in_ready & ~clear;
   assign pop  = out_valid & out_ready & ~clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         sig        <= '0;
         word_cnt   <= '0;
         stall_seen <= 1'b0;
      end else if (clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         sig        <= '0;
         word_cnt   <= '0;
         stall_seen <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + 1'b1;
            sig      <= sig ^ in_data;
            word_cnt <= word_cnt + 16'd1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
         if (in_valid && !in_ready)
            stall_seen <= 1'b1;
      end
   end

   // Storage is left unreset; empty slots are masked on out_data.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_data;
   end

endmodule

// File: tb/tb_output_capture_fifo.sv
// Bench for output_capture_fifo: directed scenarios plus random traffic
// checked each cycle against a queue-based reference model.
module tb_output_capture_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clear;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sig;
   logic [15:0]      word_cnt;
   logic             stall_seen;

   int checks = 0;
   int failures = 0;

   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] m_sig;
   logic [15:0]      m_cnt;
   logic             m_stall;

   output_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .sig(sig), .word_cnt(word_cnt), .stall_seen(stall_seen)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_sig   = '0;
      m_cnt   = '0;
      m_stall = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      logic [WIDTH-1:0] exp_data;
      exp_data = (q.size() > 0) ? q[0] : '0;
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(q.size() < DEPTH));
      chk({tag, "_out_valid"}, 64'(out_valid), 64'(q.size() > 0));
      chk({tag, "_out_data"}, 64'(out_data), 64'(exp_data));
      chk({tag, "_sig"}, 64'(sig), 64'(m_sig));
      chk({tag, "_word_cnt"}, 64'(word_cnt), 64'(m_cnt));
      chk({tag, "_stall"}, 64'(stall_seen), 64'(m_stall));
   endtask

   // One clock: check at negedge, then apply the model at the posedge.
   task automatic cycle(input string tag);
      bit rdy, vld;
      @(negedge clk);
      check_outputs(tag);
      rdy = (q.size() < DEPTH);
      vld = (q.size() > 0);
      @(posedge clk);
      if (clear) begin
         model_reset();
      end else begin
         if (in_valid && !rdy) m_stall = 1'b1;
         if (vld && out_ready) void'(q.pop_front());
         if (in_valid && rdy) begin
            q.push_back(in_data);
            m_sig ^= in_data;
            m_cnt += 16'd1;
         end
      end
      #1;
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      clear     = 1'b0;
      in_data   = '0;
   endtask

   task automatic do_clear();
      idle();
      clear = 1'b1;
      cycle("clr");
      clear = 1'b0;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      model_reset();
      #2;
      check_outputs("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle("post_reset");

      // Single word
      in_valid = 1'b1;
      in_data  = 32'hC000_0003;
      cycle("single_push");
      in_valid = 1'b0;
      cycle("single_hold");
      chk("single_data", 64'(out_data), 64'h0000_0000_C000_0003);
      chk("single_cnt", 64'(word_cnt), 64'd1);
      do_clear();

      // Fill to full, hold in_valid, then drain in order
      in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_data = WIDTH'(i);
         cycle("fill");
      end
      in_data = 32'h5;
      cycle("full_hold");
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_stall", 64'(stall_seen), 64'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("drain_first", 64'(out_data), 64'd1);
      chk("full_pop_rdy", 64'(in_ready), 64'd0);
      @(posedge clk);
      void'(q.pop_front());
      #1;
      chk("rdy_after_pop", 64'(in_ready), 64'd1);
      for (int i = 0; i < 3; i++) cycle("drain");
      chk("drained", 64'(out_valid), 64'd0);
      do_clear();

      // Streaming with one word in flight, pointers wrap
      in_valid = 1'b1;
      in_data  = 32'h100;
      cycle("stream_pre");
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = $urandom;
         cycle("stream");
         chk("stream_count", 64'(q.size()), 64'd1);
      end
      do_clear();

      // Signature
      in_valid = 1'b1;
      in_data  = 32'hC000_0003;
      cycle("sig1");
      in_data = 32'h3FFF_FFFC;
      cycle("sig2");
      in_valid = 1'b0;
      cycle("sig_hold");
      chk("sig_value", 64'(sig), 64'hFFFF_FFFF);
      chk("sig_cnt", 64'(word_cnt), 64'd2);

      // Clear with a concurrent push
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      clear    = 1'b1;
      cycle("clear_push");
      idle();
      cycle("after_clear");
      chk("clear_sig", 64'(sig), 64'd0);
      chk("clear_valid", 64'(out_valid), 64'd0);

      // word_cnt wraparound
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         in_data = $urandom;
         cycle("wrap_fill");
      end
      chk("cnt_ffff", 64'(word_cnt), 64'hFFFF);
      in_data = 32'h1;
      cycle("wrap_last");
      chk("cnt_wrap", 64'(word_cnt), 64'd0);
      do_clear();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 2) != 0);
         in_data   = $urandom;
         clear     = ($urandom_range(0, 39) == 0);
         cycle("rand");
      end
      idle();

      // Async reset with buffered words
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = $urandom;
         cycle("pre_reset");
      end
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_valid", 64'(out_valid), 64'd0);
      chk("async_ready", 64'(in_ready), 64'd1);
      chk("async_sig", 64'(sig), 64'd0);
      chk("async_cnt", 64'(word_cnt), 64'd0);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/output_capture_fifo.md
OUTPUT_CAPTURE_FIFO -- requirements
Module: output_capture_fifo

Interface
- REQ-001 The block SHALL provide parameter WIDTH, default 32, data word width in bits.
- REQ-002 The block SHALL provide parameter DEPTH, default 4, FIFO entries; legal values are 2, 4, 8 or 16.
- REQ-003 The block SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-004 The block SHALL provide port rst_n, input, 1, reset; asynchronous, active-low.
- REQ-005 The block SHALL provide port clear, input, 1, synchronous flush of FIFO, signature and counters.
- REQ-006 The block SHALL provide port in_data, input, WIDTH, the word from the upstream (a|b)^constant stage output y.
- REQ-007 The block SHALL provide port in_valid, input, 1, upstream word valid.
- REQ-008 The block SHALL provide port in_ready, output, 1, block can accept a word this cycle.
- REQ-009 The block SHALL provide port out_data, output, WIDTH, head-of-FIFO word.
- REQ-010 The block SHALL provide port out_valid, output, 1, out_data holds a valid word.
- REQ-011 The block SHALL provide port out_ready, input, 1, downstream accepts the head word.
- REQ-012 The block SHALL provide port sig, output, WIDTH, running XOR of all accepted input words.
- REQ-013 The block SHALL provide port word_cnt, output, 16, count of accepted input words.
- REQ-014 The block SHALL provide port stall_seen, output, 1, sticky flag for in_valid=1 while in_ready=0.

Function
- REQ-015 The block SHALL push when in_valid && in_ready, and pop when out_valid && out_ready, at the rising clk edge.
- REQ-016 The block SHALL hold occupancy count in range 0..DEPTH, with count'=count+push-pop.
- REQ-017 The block SHALL drive in_ready = (count < DEPTH), from registered state only, with no combinational path from out_ready.
- REQ-018 The block SHALL drive out_valid = (count > 0), and out_data = entry at read pointer when out_valid=1, else all zeros.
- REQ-019 The block SHALL make a word pushed at edge N visible on out_data/out_valid after edge N (1-cycle latency); no same-cycle bypass.
- REQ-020 The block SHALL, when full and out_ready=1, still hold in_ready=0 that cycle; the pop occurs, and in_ready rises the next cycle.
- REQ-021 The block SHALL, when empty and a push occurs, perform no pop that cycle, since out_valid=0.
- REQ-022 The block SHALL, on simultaneous push and pop with 0<count<DEPTH, leave count unchanged and advance both pointers.
- REQ-023 The block SHALL wrap read and write pointers modulo DEPTH.
- REQ-024 The block SHALL preserve word order: output order equals acceptance order, and no word is duplicated or dropped.
- REQ-025 The block SHALL update sig <= sig ^ in_data on each push.
- REQ-026 The block SHALL increment word_cnt by 1 on each push, wrapping from 0xFFFF to 0x0000.
- REQ-027 The block SHALL set stall_seen on any cycle with in_valid=1 and in_ready=0; it clears only on clear or reset.
- REQ-028 The block SHALL, when clear=1, set count, pointers, sig, word_cnt and stall_seen to 0 at the edge; clear overrides any push or pop that cycle, and the word is not accepted.
- REQ-029 The block SHALL drive in_ready with the normal rule during clear, but ignore any push that cycle.

Reset
- REQ-030 The block SHALL, while rst_n=0, immediately force count=0, both pointers=0, sig=0, word_cnt=0 and stall_seen=0, independent of clk.
- REQ-031 The block SHALL drive in_ready=1, out_valid=0 and out_data=0 during reset and after reset release.
- REQ-032 The block SHALL leave storage array contents unreset; they are unobservable because out_data is masked when empty.
- REQ-033 The block SHALL, if reset is asserted mid-transfer, discard all buffered words; no word accepted before reset appears after it.

Verification
- REQ-034 Single word: push 0xC0000003 with out_ready=0 -> next cycle out_valid=1, out_data=0xC0000003, sig=0xC0000003, word_cnt=1.
- REQ-035 Fill/full: DEPTH=4, push 0x1, 0x2, 0x3, 0x4 with out_ready=0 -> in_ready=0, stall_seen=1 when in_valid is held high; then out_ready=1 -> pops 0x1, 0x2, 0x3, 0x4 in order, and in_ready=1 one cycle after the first pop.
- REQ-036 Streaming: in_valid=1 and out_ready=1 continuously with count=1 -> count stays 1 and throughput is 1 word/cycle; pointers wrap past 3 without loss over 10 words.
- REQ-037 Signature: push 0xC0000003 then 0x3FFFFFFC -> sig=0xFFFFFFFF, word_cnt=2.
- REQ-038 Clear and counter: clear=1 with a concurrent push of 0xDEADBEEF -> count=0, sig=0, word_cnt=0, and 0xDEADBEEF is never output; preload word_cnt to 0xFFFF via 65535 pushes, then one more push -> word_cnt=0x0000.
- REQ-039 Async reset: assert rst_n=0 between clk edges with 3 words buffered -> out_valid=0, in_ready=1 and sig=0 immediately, before the next edge.
